// File: rtl/mfp_eic_arbiter_pkg.sv
// Shared definitions for the EIC priority arbiter: channel count default,
// priority width, sequencer state encoding and an index-width helper.
package mfp_eic_arbiter_pkg;

  localparam int unsigned EIC_CHANNELS   = 8;
  localparam int unsigned EIC_PRIO_WIDTH = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_e;

  // Width of a channel index; a single-channel build still needs one address bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mfp_eic_arbiter_if.sv
// Bundle of sense-logic, priority-config and EIC CPU-port signals for the
// arbiter. The master view belongs to the arbiter; the slave view to its
// surroundings (pending sources, config bus, CPU).
interface mfp_eic_arbiter_if
  import mfp_eic_arbiter_pkg::*;
#(
  parameter int unsigned CHANNELS = EIC_CHANNELS
);
  localparam int unsigned AW = idx_width(CHANNELS);

  logic [CHANNELS-1:0]       pending;
  logic [CHANNELS-1:0]       clear;
  logic                      cfg_we;
  logic [AW-1:0]             cfg_addr;
  logic [EIC_PRIO_WIDTH-1:0] cfg_wdata;
  logic [EIC_PRIO_WIDTH-1:0] cfg_rdata;
  logic [7:0]                EIC_Interrupt;
  logic [5:0]                EIC_Vector;
  logic [16:0]               EIC_Offset;
  logic [3:0]                EIC_ShadowSet;
  logic                      EIC_IAck;
  logic                      busy;

  modport master (
    input  pending, cfg_we, cfg_addr, cfg_wdata, EIC_IAck,
    output clear, cfg_rdata, EIC_Interrupt, EIC_Vector, EIC_Offset,
           EIC_ShadowSet, busy
  );

  modport slave (
    output pending, cfg_we, cfg_addr, cfg_wdata, EIC_IAck,
    input  clear, cfg_rdata, EIC_Interrupt, EIC_Vector, EIC_Offset,
           EIC_ShadowSet, busy
  );

endinterface

// File: rtl/mfp_eic_arbiter_prio_select.sv
// Combinational max-priority selector. Scans channels starting at start_i
// and wrapping; a strictly-greater compare means the first channel reached
// wins a tie, so start_i = 0 gives lowest-index-wins.
module mfp_eic_prio_select
  import mfp_eic_arbiter_pkg::*;
#(
  parameter int unsigned CHANNELS = EIC_CHANNELS,
  parameter int unsigned AW       = idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0]       cand_i,
  input  logic [EIC_PRIO_WIDTH-1:0] prio_i [CHANNELS],
  input  logic [AW-1:0]             start_i,
  output logic                      valid_o,
  output logic [AW-1:0]             idx_o,
  output logic [EIC_PRIO_WIDTH-1:0] prio_o
);

  int unsigned   pos;
  logic [AW-1:0] idx;

  // Rotating scan keeping the first highest-priority candidate found.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    prio_o  = '0;
    pos     = 0;
    idx     = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      pos = 32'(start_i) + k;
      if (pos >= CHANNELS) pos = pos - CHANNELS;
      idx = AW'(pos);
      if (cand_i[idx] && (prio_i[idx] > prio_o)) begin
        valid_o = 1'b1;
        idx_o   = idx;
        prio_o  = prio_i[idx];
      end
    end
  end

endmodule

// File: rtl/mfp_eic_arbiter.sv
// EIC priority arbiter/sequencer: chooses the highest-priority enabled
// pending channel, presents it on the EIC CPU port, waits for IAck and
// pulses a clear back to the sense logic.
// Optional feature: define EIC_ARB_ROUND_ROBIN_EN for rotating tie-break.
module mfp_eic_arbiter
  import mfp_eic_arbiter_pkg::*;
#(
  parameter int unsigned CHANNELS     = EIC_CHANNELS,
  parameter int unsigned SPACING_LOG2 = 5,
  parameter int unsigned SHADOW_SET   = 0
) (
  input logic               CLK,
  input logic               RESET,
  mfp_eic_arbiter_if.master bus
);

  localparam int unsigned AW = idx_width(CHANNELS);
  localparam int unsigned PW = EIC_PRIO_WIDTH;

  logic [PW-1:0]       prio_q [CHANNELS];
  logic [CHANNELS-1:0] cand;
  logic                addr_ok;

  arb_state_e          state_q, state_d;
  logic [AW-1:0]       chan_q, chan_d;
  logic [PW-1:0]       pprio_q, pprio_d;
  logic [CHANNELS-1:0] clear_q, clear_d;

  logic                win_valid;
  logic [AW-1:0]       win_idx;
  logic [PW-1:0]       win_prio;
  logic [AW-1:0]       rr_start;
  logic [PW-1:0]       cur_prio;

  assign addr_ok = (32'(bus.cfg_addr) < CHANNELS);

  // Priority register file; out-of-range writes are dropped.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < CHANNELS; i++) prio_q[i] <= '0;
    end else if (bus.cfg_we && addr_ok) begin
      prio_q[bus.cfg_addr] <= bus.cfg_wdata;
    end
  end

  assign bus.cfg_rdata = addr_ok ? prio_q[bus.cfg_addr] : '0;

  // A channel competes only when pending and enabled (non-zero priority).
  always_comb begin
    cand = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cand[i] = bus.pending[i] && (prio_q[i] != '0);
    end
  end

  mfp_eic_prio_select #(
    .CHANNELS (CHANNELS),
    .AW       (AW)
  ) u_select (
    .cand_i  (cand),
    .prio_i  (prio_q),
    .start_i (rr_start),
    .valid_o (win_valid),
    .idx_o   (win_idx),
    .prio_o  (win_prio)
  );

`ifdef EIC_ARB_ROUND_ROBIN_EN
  logic [AW-1:0] rr_q, rr_d;

  // Next tie-break start is the channel after the one being acknowledged.
  always_comb begin
    rr_d = (32'(chan_q) == CHANNELS - 1) ? '0 : chan_q + 1'b1;
  end

  // Rotation pointer advances only on an accepted acknowledge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_q <= '0;
    end else if ((state_q == ST_REQ) && bus.EIC_IAck) begin
      rr_q <= rr_d;
    end
  end

  assign rr_start = rr_q;
`else
  assign rr_start = '0;
`endif

  assign cur_prio = prio_q[chan_q];

  // Sequencer state and presented-request registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
      pprio_q <= '0;
      clear_q <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      pprio_q <= pprio_d;
      clear_q <= clear_d;
    end
  end

  // Next-state: present, preempt, withdraw or acknowledge (IAck has priority).
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    pprio_d = pprio_q;
    clear_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_REQ;
          chan_d  = win_idx;
          pprio_d = win_prio;
        end
      end
      ST_REQ: begin
        if (bus.EIC_IAck) begin
          state_d         = ST_ACK;
          clear_d[chan_q] = 1'b1;
          chan_d          = '0;
          pprio_d         = '0;
        end else if (!cand[chan_q]) begin
          state_d = ST_IDLE;
          chan_d  = '0;
          pprio_d = '0;
        end else if (win_prio > cur_prio) begin
          chan_d  = win_idx;
          pprio_d = win_prio;
        end else begin
          // Keep the presented channel but track a rewritten priority.
          pprio_d = cur_prio;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        chan_d  = '0;
        pprio_d = '0;
      end
    endcase
  end

  assign bus.clear         = clear_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.EIC_Interrupt = {2'b00, pprio_q};
  assign bus.EIC_Vector    = 6'(chan_q);
  assign bus.EIC_Offset    = 17'((18'(chan_q) << SPACING_LOG2) >> 1);
  assign bus.EIC_ShadowSet = (state_q == ST_REQ) ? 4'(SHADOW_SET) : '0;

endmodule

// File: tb/tb_mfp_eic_arbiter.sv
// Directed self-checking bench for mfp_eic_arbiter with a scoreboard queue
// of expected post-edge outputs.
module tb_mfp_eic_arbiter;

  localparam int unsigned CH = 6;

  logic CLK;
  logic RESET;

  mfp_eic_arbiter_if #(.CHANNELS(CH)) bus ();

  mfp_eic_arbiter #(
    .CHANNELS     (CH),
    .SPACING_LOG2 (5),
    .SHADOW_SET   (3)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [7:0]  intr;
    logic [5:0]  vec;
    logic [16:0] off;
    logic [3:0]  sh;
    logic [5:0]  clr;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(string tag, int ch, int pr, logic [5:0] clr, logic busy);
    exp_t e;
    e.tag  = tag;
    e.clr  = clr;
    e.busy = busy;
    if (pr == 0) begin
      e.intr = '0; e.vec = '0; e.off = '0; e.sh = '0;
    end else begin
      e.intr = 8'(pr);
      e.vec  = 6'(ch);
      e.off  = 17'((ch * 32) / 2);
      e.sh   = 4'd3;
    end
    return e;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(exp_t e);
    exp_t g;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    g = sb.pop_front();
    check({g.tag, ".intr"},  32'(bus.EIC_Interrupt), 32'(g.intr));
    check({g.tag, ".vec"},   32'(bus.EIC_Vector),    32'(g.vec));
    check({g.tag, ".off"},   32'(bus.EIC_Offset),    32'(g.off));
    check({g.tag, ".sh"},    32'(bus.EIC_ShadowSet), 32'(g.sh));
    check({g.tag, ".clr"},   32'(bus.clear),         32'(g.clr));
    check({g.tag, ".busy"},  32'(bus.busy),          32'(g.busy));
    @(negedge CLK);
  endtask

  task automatic wr(logic [2:0] a, logic [5:0] d, exp_t e);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    tick(e);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic rd(string tag, logic [2:0] a, logic [5:0] exp);
    bus.cfg_addr = a;
    #1;
    check(tag, 32'(bus.cfg_rdata), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    RESET         = 1'b1;
    bus.pending   = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_wdata = '0;
    bus.EIC_IAck  = 1'b0;
    @(negedge CLK);
    tick(mk("reset", 0, 0, 6'h00, 1'b0));
    rd("reset_rd0", 3'd0, 6'd0);
    RESET = 1'b0;

    // Basic presentation with one-cycle latency
    wr(3'd3, 6'd5, mk("wr3", 0, 0, 6'h00, 1'b0));
    rd("rd3", 3'd3, 6'd5);
    wr(3'd7, 6'd9, mk("wr_oob", 0, 0, 6'h00, 1'b0));
    rd("rd_oob7", 3'd7, 6'd0);
    rd("rd_oob6", 3'd6, 6'd0);
    bus.pending = 6'h08;
    tick(mk("present3", 3, 5, 6'h00, 1'b1));

    // Preemption by higher priority
    wr(3'd4, 6'd9, mk("wr4_hold", 3, 5, 6'h00, 1'b1));
    bus.pending = 6'h18;
    tick(mk("preempt4", 4, 9, 6'h00, 1'b1));

    // Acknowledge: clear pulse, ACK cycle, then re-arbitrate
    bus.EIC_IAck = 1'b1;
    tick(mk("ack4", 0, 0, 6'h10, 1'b1));
    bus.EIC_IAck = 1'b0;
    bus.pending  = 6'h08;
    tick(mk("ack_idle", 0, 0, 6'h00, 1'b0));
    bus.EIC_IAck = 1'b1;
    tick(mk("iack_in_idle", 3, 5, 6'h00, 1'b1));
    bus.EIC_IAck = 1'b0;

    // Withdraw when pending drops
    bus.pending = 6'h00;
    tick(mk("withdraw", 0, 0, 6'h00, 1'b0));

    // Equal priority never preempts; IAck beats withdraw
    wr(3'd5, 6'd5, mk("wr5", 0, 0, 6'h00, 1'b0));
    bus.pending = 6'h08;
    tick(mk("re_present3", 3, 5, 6'h00, 1'b1));
    bus.pending = 6'h28;
    tick(mk("eq_no_preempt", 3, 5, 6'h00, 1'b1));
    bus.pending  = 6'h20;
    bus.EIC_IAck = 1'b1;
    tick(mk("iack_beats_wd", 0, 0, 6'h08, 1'b1));
    bus.EIC_IAck = 1'b0;
    tick(mk("ack_to_idle", 0, 0, 6'h00, 1'b0));
    tick(mk("present5", 5, 5, 6'h00, 1'b1));
    wr(3'd5, 6'd0, mk("prio5_still", 5, 5, 6'h00, 1'b1));
    tick(mk("prio0_withdraw", 0, 0, 6'h00, 1'b0));
    bus.pending = 6'h00;

    // Tie-break between channels 1 and 2
    wr(3'd1, 6'd7, mk("wr1", 0, 0, 6'h00, 1'b0));
    wr(3'd2, 6'd7, mk("wr2", 0, 0, 6'h00, 1'b0));
    bus.pending = 6'h06;
    tick(mk("tie_first", 1, 7, 6'h00, 1'b1));
    bus.EIC_IAck = 1'b1;
    tick(mk("ack1", 0, 0, 6'h02, 1'b1));
    bus.EIC_IAck = 1'b0;
    tick(mk("ack1_idle", 0, 0, 6'h00, 1'b0));
`ifdef EIC_ARB_ROUND_ROBIN_EN
    tick(mk("tie_after_ack", 2, 7, 6'h00, 1'b1));
`else
    tick(mk("tie_after_ack", 1, 7, 6'h00, 1'b1));
`endif
    bus.pending = 6'h00;
    tick(mk("withdraw_tie", 0, 0, 6'h00, 1'b0));

    // Reset while in ACK
    bus.pending = 6'h08;
    tick(mk("present3_b", 3, 5, 6'h00, 1'b1));
    bus.EIC_IAck = 1'b1;
    tick(mk("ack3_b", 0, 0, 6'h08, 1'b1));
    bus.EIC_IAck = 1'b0;
    RESET        = 1'b1;
    tick(mk("reset_in_ack", 0, 0, 6'h00, 1'b0));
    RESET = 1'b0;
    rd("rst_rd3", 3'd3, 6'd0);
    rd("rst_rd1", 3'd1, 6'd0);
    tick(mk("no_prio_after_rst", 0, 0, 6'h00, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
